hcsr04_echo_responder: RTL

//  Emulates the HC-SR04 sensor side of the radar's ultrasonic trig/echo link: watches the trig line and answers with an echo pulse.

---
 rtl/hcsr04_echo_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor emulator: answers a trig pulse with an echo whose width encodes distance_cm.
// Timing is derived from a us prescaler that restarts on every FSM state change.
module hcsr04_echo_responder #(
    parameter int unsigned CLK_PER_US    = 50,
    parameter int unsigned TRIG_MIN_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 250,
    parameter int unsigned US_PER_CM     = 58,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned TIMEOUT_US    = 38000,
    parameter int unsigned HOLDOFF_US    = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trig,
    input  logic       enable,
    input  logic [9:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic [7:0] meas_count
);

    localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
    localparam logic [16:0] TRIG_MIN    = 17'(TRIG_MIN_US);
    localparam logic [15:0] DELAY_LEN   = 16'(ECHO_DELAY_US);
    localparam logic [15:0] HOLDOFF_LEN = 16'(HOLDOFF_US);
    localparam logic [15:0] TIMEOUT_LEN = 16'(TIMEOUT_US);
    localparam logic [15:0] CM_SCALE    = 16'(US_PER_CM);
    localparam logic [9:0]  MAX_DIST    = 10'(MAX_CM);

    typedef enum logic [2:0] {
        StIdle,
        StTrigHi,
        StDelay,
        StEcho,
        StHoldoff
    } state_e;

    state_e state_q, state_d;

    logic          trig_s1, trig_s2, trig_prev;
    logic          rise_q, fall_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   us_cnt_q;
    logic [15:0]   width_q;
    logic          echo_q, trig_err_q;
    logic [7:0]    meas_count_q;

    logic          us_tick;
    logic [16:0]   us_elapsed;
    logic          trig_ok;
    logic [15:0]   state_len;
    logic          timer_done;
    logic          dist_in_range;
    logic [15:0]   dist_width;
    logic          latch_en, err_set, meas_inc;

    // Two-flop synchroniser followed by a registered edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_prev <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            trig_s1   <= trig;
            trig_s2   <= trig_s1;
            trig_prev <= trig_s2;
            rise_q    <= trig_s2 & ~trig_prev;
            fall_q    <= ~trig_s2 & trig_prev;
        end
    end

    assign us_tick = (presc_q == PRESC_LAST);

    // Elapsed us including a tick that lands on this cycle, so a trig of exactly
    // TRIG_MIN_US is accepted.
    assign us_elapsed = {1'b0, us_cnt_q} + 17'(us_tick);
    assign trig_ok    = (us_elapsed >= TRIG_MIN);

    always_comb begin
        state_len = 16'd0;
        case (state_q)
            StDelay:   state_len = DELAY_LEN;
            StEcho:    state_len = width_q;
            StHoldoff: state_len = HOLDOFF_LEN;
            default:   state_len = 16'd0;
        endcase
    end

    assign timer_done = us_tick && (us_cnt_q == state_len - 16'd1);

    assign dist_in_range = (distance_cm != 10'd0) && (distance_cm <= MAX_DIST);
    assign dist_width    = dist_in_range ? ({6'd0, distance_cm} * CM_SCALE) : TIMEOUT_LEN;

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        err_set  = 1'b0;
        meas_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise_q && enable) state_d = StTrigHi;
            end
            StTrigHi: begin
                if (fall_q) begin
                    if (trig_ok) begin
                        state_d  = StDelay;
                        latch_en = 1'b1;
                    end else begin
                        state_d = StIdle;
                        err_set = 1'b1;
                    end
                end
            end
            StDelay: begin
                if (timer_done) state_d = StEcho;
            end
            StEcho: begin
                if (timer_done) begin
                    state_d  = StHoldoff;
                    meas_inc = 1'b1;
                end
            end
            StHoldoff: begin
                if (timer_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            us_cnt_q     <= 16'd0;
            width_q      <= 16'd0;
            echo_q       <= 1'b0;
            trig_err_q   <= 1'b0;
            meas_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                presc_q  <= '0;
                us_cnt_q <= 16'd0;
            end else if (us_tick) begin
                presc_q <= '0;
                // Saturate so a trig held high forever cannot wrap the count.
                if (us_cnt_q != 16'hffff) us_cnt_q <= us_cnt_q + 16'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            if (latch_en) width_q <= dist_width;
            echo_q     <= (state_d == StEcho);
            trig_err_q <= err_set;
            if (meas_inc) meas_count_q <= meas_count_q + 8'd1;
        end
    end

    assign echo       = echo_q;
    assign busy       = (state_q != StIdle);
    assign trig_err   = trig_err_q;
    assign meas_count = meas_count_q;

endmodule
